dm_lsu: RTL and testbench

Load/store sequencer placed directly upstream of the 8-bit, 256-entry data memory, driving its address, write_data, mem_write and mem_read pins.
Accepts single or burst (1-8 beat) read/write requests over a valid/ready handshake.
Generates exactly one memory strobe per beat and auto-increments the address, wrapping at 8 bits.
Returns read data per beat with backpressure, so the core-side master never sees raw memory timing.

---
 rtl/dm_lsu.sv | 134 +++++++++++++
 tb/tb_dm_lsu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// Burst load/store sequencer for the 8-bit x 256-entry data memory.
// Turns 1-8 beat requests into one memory strobe per beat and buffers load data.
module dm_lsu #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [2:0] req_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] dm_address,
  output logic [7:0] dm_write_data,
  output logic       dm_mem_write,
  output logic       dm_mem_read,
  input  logic [7:0] dm_read_data,
  output logic [2:0] state_dbg
);

  // Handshake rule for req, wr and rd channels: a transfer occurs on a rising
  // clk edge where valid and ready are both high; valid never waits on ready.
  typedef enum logic [2:0] {
    S_IDLE, S_WR_WAIT, S_WR_PULSE, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] addr, addr_next;
  logic [2:0] len, len_next;
  logic [2:0] beat, beat_next;
  logic [2:0] wait_cnt, wait_next;
  logic       last_beat;

  assign last_beat = (beat == len);
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign wr_ready  = (state == S_WR_WAIT);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    addr_next  = addr;
    len_next   = len;
    beat_next  = beat;
    wait_next  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          addr_next  = req_addr;
          len_next   = req_len;
          beat_next  = 3'd0;
          state_next = req_write ? S_WR_WAIT : S_RD_ISSUE;
        end
      end
      S_WR_WAIT: begin
        if (wr_valid) state_next = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (last_beat) begin
          state_next = S_DONE;
        end else begin
          addr_next  = addr + 8'd1;
          beat_next  = beat + 3'd1;
          state_next = S_WR_WAIT;
        end
      end
      S_RD_ISSUE: begin
        wait_next  = 3'(READ_LATENCY);
        state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Last wait cycle is the one where memory data is valid.
        wait_next = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) state_next = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (rd_ready) begin
          if (last_beat) begin
            state_next = S_DONE;
          end else begin
            addr_next  = addr + 8'd1;
            beat_next  = beat + 3'd1;
            state_next = S_RD_ISSUE;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      addr          <= 8'd0;
      len           <= 3'd0;
      beat          <= 3'd0;
      wait_cnt      <= 3'd0;
      rd_data       <= 8'd0;
      rd_valid      <= 1'b0;
      done          <= 1'b0;
      dm_address    <= 8'd0;
      dm_write_data <= 8'd0;
      dm_mem_write  <= 1'b0;
      dm_mem_read   <= 1'b0;
    end else begin
      state        <= state_next;
      addr         <= addr_next;
      len          <= len_next;
      beat         <= beat_next;
      wait_cnt     <= wait_next;
      dm_mem_write <= (state_next == S_WR_PULSE);
      dm_mem_read  <= (state_next == S_RD_ISSUE);
      rd_valid     <= (state_next == S_RD_OUT);
      done         <= (state_next == S_DONE);
      if (state_next == S_WR_PULSE) begin
        dm_address    <= addr_next;
        dm_write_data <= wr_data;
      end
      if (state_next == S_RD_ISSUE) dm_address <= addr_next;
      if (state == S_RD_WAIT && state_next == S_RD_OUT) rd_data <= dm_read_data;
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: two instances (read latency 1 and 3) exercised in turn,
// each with its own data memory model; a negedge monitor checks against queues.
module tb_dm_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] reset     = 2'b11;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_write = 2'b00;
  logic [1:0] wr_valid  = 2'b00;
  logic [1:0] rd_ready  = 2'b00;
  logic [7:0] req_addr [2];
  logic [2:0] req_len [2];
  logic [7:0] wr_data [2];

  logic [1:0] req_ready, wr_ready, rd_valid, busy, done, dm_mem_write, dm_mem_read;
  logic [7:0] rd_data [2];
  logic [7:0] dm_address [2];
  logic [7:0] dm_write_data [2];
  logic [7:0] dm_read_data [2];
  logic [2:0] state_dbg [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : 3;
    // Memory power-on contents: address 0 reads 0xFF, everything else 0x00.
    logic [7:0] mem [256] = '{0: 8'hFF, default: 8'h00};
    logic [7:0] pipe [4] = '{default: 8'h00};

    dm_lsu #(.READ_LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset[k]),
      .req_valid(req_valid[k]), .req_ready(req_ready[k]), .req_write(req_write[k]),
      .req_addr(req_addr[k]), .req_len(req_len[k]),
      .wr_data(wr_data[k]), .wr_valid(wr_valid[k]), .wr_ready(wr_ready[k]),
      .rd_data(rd_data[k]), .rd_valid(rd_valid[k]), .rd_ready(rd_ready[k]),
      .busy(busy[k]), .done(done[k]),
      .dm_address(dm_address[k]), .dm_write_data(dm_write_data[k]),
      .dm_mem_write(dm_mem_write[k]), .dm_mem_read(dm_mem_read[k]),
      .dm_read_data(dm_read_data[k]), .state_dbg(state_dbg[k])
    );

    always @(posedge clk) begin
      pipe[0] <= mem[dm_address[k]];
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
      if (dm_mem_write[k]) mem[dm_address[k]] <= dm_write_data[k];
    end
    assign dm_read_data[k] = pipe[LAT-1];
  end

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_ra_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  vec [8];
  int checks = 0, fails = 0;
  int cur = 0, lat_exp = 1, done_cnt = 0, cyc = 0, issue_cyc = 0;
  logic prev_rv = 1'b0, prev_done = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (dut %0d, cycle %0d)", name, act, exp, cur, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: got an unexpected event, expected none (dut %0d, cycle %0d)", name, cur, cyc);
  endtask

  // Monitor: pops expected strobes and load beats whenever the DUT presents them.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset[cur]) begin
      prev_rv   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (dm_mem_write[cur] || dm_mem_read[cur])
        check("one_strobe", 16'(dm_mem_write[cur] & dm_mem_read[cur]), 16'd0);
      if (dm_mem_write[cur]) begin
        if (exp_wr_q.size() == 0) note_fail("wr_strobe");
        else check("wr_strobe", {dm_address[cur], dm_write_data[cur]}, exp_wr_q.pop_front());
      end
      if (dm_mem_read[cur]) begin
        issue_cyc = cyc;
        check("rd_issue_while_valid", 16'(rd_valid[cur]), 16'd0);
        if (exp_ra_q.size() == 0) note_fail("rd_strobe");
        else check("rd_strobe_addr", 16'(dm_address[cur]), 16'(exp_ra_q.pop_front()));
      end
      if (rd_valid[cur]) begin
        if (!prev_rv) check("rd_latency", 16'(cyc - issue_cyc), 16'(lat_exp + 1));
        if (exp_rd_q.size() == 0) note_fail("rd_beat");
        else begin
          check("rd_data", 16'(rd_data[cur]), 16'(exp_rd_q[0]));
          if (rd_ready[cur]) void'(exp_rd_q.pop_front());
        end
      end
      if (done[cur]) begin
        check("done_width", 16'(prev_done), 16'd0);
        done_cnt++;
      end
      prev_rv   = rd_valid[cur];
      prev_done = done[cur];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
    vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 16'(req_ready[cur]), 16'd1);
    check("rst_flags", 16'({busy[cur], wr_ready[cur], rd_valid[cur], done[cur],
                            dm_mem_write[cur], dm_mem_read[cur]}), 16'd0);
    check("rst_dm_bus", {dm_address[cur], dm_write_data[cur]}, 16'h0000);
    check("rst_rd_data", 16'(rd_data[cur]), 16'd0);
    check("rst_state", 16'(state_dbg[cur]), 16'd0);
  endtask

  task automatic send_req(input logic w, input logic [7:0] a, input logic [2:0] l);
    int n = 0;
    req_write[cur] = w;
    req_addr[cur]  = a;
    req_len[cur]   = l;
    req_valid[cur] = 1'b1;
    while (!req_ready[cur] && n < 50) begin tick(); n++; end
    check("req_accept", 16'(req_ready[cur]), 16'd1);
    tick();
    req_valid[cur] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin tick(); n++; end
    check("done_count", 16'(done_cnt), 16'(target));
    tick();
    check("idle_after_done", 16'(req_ready[cur]), 16'd1);
  endtask

  // stop < number of beats abandons the burst with a reset in WR_WAIT of beat 'stop'.
  task automatic store(input logic [7:0] a, input logic [2:0] l, input int stop);
    int d0 = done_cnt;
    int n;
    for (int i = 0; i <= int'(l) && i < stop; i++) exp_wr_q.push_back({8'(a + i), vec[i]});
    send_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      n = 0;
      while (!wr_ready[cur] && n < 20) begin tick(); n++; end
      check("wr_ready", 16'(wr_ready[cur]), 16'd1);
      if (i == stop) begin
        #2;
        reset[cur] = 1'b1;
        #1;
        check_reset_outputs();
        tick();
        tick();
        reset[cur] = 1'b0;
        tick();
        tick();
        check("no_done_after_abort", 16'(done_cnt), 16'(d0));
        return;
      end
      wr_data[cur]  = vec[i];
      wr_valid[cur] = 1'b1;
      tick();
      wr_valid[cur] = 1'b0;
    end
    wait_done(d0 + 1);
  endtask

  // hold: cycles rd_ready stays low on beat 0 while a stray request and store beat are offered.
  task automatic load(input logic [7:0] a, input logic [2:0] l, input int hold);
    int d0 = done_cnt;
    int n;
    for (int i = 0; i <= int'(l); i++) begin
      exp_ra_q.push_back(8'(a + i));
      exp_rd_q.push_back(vec[i]);
    end
    send_req(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      n = 0;
      while (!rd_valid[cur] && n < 20) begin tick(); n++; end
      check("rd_valid", 16'(rd_valid[cur]), 16'd1);
      if (i == 0 && hold > 0) begin
        req_write[cur] = 1'b1;
        req_addr[cur]  = 8'h77;
        req_valid[cur] = 1'b1;
        wr_data[cur]   = 8'h5A;
        wr_valid[cur]  = 1'b1;
        for (int h = 0; h < hold; h++) begin
          check("req_ready_busy", 16'({req_ready[cur], busy[cur], rd_valid[cur]}), 16'b011);
          tick();
        end
        req_valid[cur] = 1'b0;
        wr_valid[cur]  = 1'b0;
      end
      rd_ready[cur] = 1'b1;
      tick();
      rd_ready[cur] = 1'b0;
    end
    wait_done(d0 + 1);
  endtask

  task automatic run_dut(input int k);
    cur     = k;
    lat_exp = (k == 0) ? 1 : 3;
    tick();
    check_reset_outputs();
    reset[k] = 1'b0;
    tick();
    set_vec(8'hFF, 8'h00, 8'h00, 8'h00); load(8'h00, 3'd0, 0);
    set_vec(8'h00, 8'h00, 8'h00, 8'h00); load(8'h01, 3'd0, 0);
    set_vec(8'hAA, 8'h00, 8'h00, 8'h00); store(8'd10, 3'd0, 8);
    load(8'd10, 3'd0, 0);
    set_vec(8'h11, 8'h22, 8'h33, 8'h44); store(8'hFE, 3'd3, 8);
    load(8'hFE, 3'd3, 0);
    load(8'hFE, 3'd1, 3);
    set_vec(8'hA1, 8'hB2, 8'hC3, 8'hD4); store(8'h40, 3'd3, 2);
    set_vec(8'hA1, 8'hB2, 8'h00, 8'h00); load(8'h40, 3'd3, 0);
    check("wr_q_empty", 16'(exp_wr_q.size()), 16'd0);
    check("ra_q_empty", 16'(exp_ra_q.size()), 16'd0);
    check("rd_q_empty", 16'(exp_rd_q.size()), 16'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_addr[k] = 8'h00;
      req_len[k]  = 3'd0;
      wr_data[k]  = 8'h00;
    end
    for (int i = 0; i < 8; i++) vec[i] = 8'h00;
    run_dut(0);
    run_dut(1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
